// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   INST_W           : instruction width
//   PC_W             : fetch address width carried in responses
//   PMEM_ALIGN_SHIFT : log2 of the backing-store word size in bytes
//   fetch_rsp_t      : response payload {inst, pc, err}
//   align_addr()     : 8-byte aligned backing-store address for a pc
package imem_responder_pkg;

  localparam int unsigned INST_W           = 32;
  localparam int unsigned PC_W             = 64;
  localparam int unsigned PMEM_ALIGN_SHIFT = 3;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              err;
  } fetch_rsp_t;

  // Clear the byte-within-word bits to form the backing-store address.
  function automatic logic [63:0] align_addr(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:PMEM_ALIGN_SHIFT], PMEM_ALIGN_SHIFT'(0)};
  endfunction

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// In-order response FIFO with synchronous clear.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clr_i        : synchronous clear (drops all entries)
//   push_i       : write push_data_i at tail
//   push_data_i  : response payload
//   pop_i        : drop head entry (only when not empty)
//   empty_o      : no entries held
//   head_o       : payload at head
module imem_responder_rsp_fifo
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       push_i,
  input  fetch_rsp_t push_data_i,
  input  logic       pop_i,
  output logic       empty_o,
  output fetch_rsp_t head_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Extra wrap bit distinguishes full from empty when indices match.
  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  fetch_rsp_t mem_q [DEPTH];

  // Advance a pointer, wrapping the index on DEPTH (need not be a power of 2).
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p.idx == IDX_W'(DEPTH - 1)) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx  = p.idx + 1'b1;
      n.wrap = p.wrap;
    end
    return n;
  endfunction

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; reset to zero so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i && !clr_i) begin
      mem_q[wr_ptr_q.idx] <= push_data_i;
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q.idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory side of the fetch interface.
// Captures the selected 32-bit instruction at request accept, delays it
// LATENCY cycles, and returns it in order through a response FIFO.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   req_valid/req_ready    : fetch request handshake, req_pc address
//   flush                  : drop every outstanding request and response
//   mem_raddr/mem_rdata    : backing-store port (combinational read)
//   rsp_valid/rsp_ready    : response handshake
//   rsp_inst/rsp_pc/rsp_err: response payload
//   busy                   : requests outstanding
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              flush,
  output logic [63:0]       mem_raddr,
  input  logic [63:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             rdy_en_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_fire, rsp_fire;
  logic             misaligned;
  fetch_rsp_t       cap_rsp;
  logic             fifo_push, fifo_empty;
  fetch_rsp_t       fifo_wdata, fifo_head;

  assign req_ready = rdy_en_q & ~flush & (count_q < CNT_W'(DEPTH));
  assign req_fire  = req_valid & req_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign mem_raddr = align_addr(PC_W'(req_pc));

  // Instruction select; misaligned requests return zero with err set.
  assign misaligned   = |req_pc[1:0];
  assign cap_rsp.pc   = PC_W'(req_pc);
  assign cap_rsp.err  = misaligned;
  assign cap_rsp.inst = misaligned ? '0 :
                        (req_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0]);

  // Holds req_ready low until the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  // The FIFO write is itself the last delay stage, so LATENCY-1 pipeline
  // registers sit between accept and the FIFO.
  generate
    if (LATENCY == 1) begin : g_direct
      assign fifo_push  = req_fire;
      assign fifo_wdata = cap_rsp;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      fetch_rsp_t         dat_q [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < int'(LATENCY) - 1; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= req_fire;
          dat_q[0] <= cap_rsp;
          for (int i = 1; i < int'(LATENCY) - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
          if (flush) vld_q <= '0;
        end
      end

      assign fifo_push  = vld_q[LATENCY-2];
      assign fifo_wdata = dat_q[LATENCY-2];
    end
  endgenerate

  imem_responder_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (rsp_fire),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Outstanding count: pipeline plus FIFO occupancy.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign rsp_valid = ~fifo_empty;
  assign rsp_inst  = fifo_head.inst;
  assign rsp_pc    = ADDR_W'(fifo_head.pc);
  assign rsp_err   = fifo_head.err;
  assign busy      = (count_q != '0);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: driver issues directed and random
// traffic; a negedge monitor predicts each cycle's response from a queue.
module tb_imem_responder;

  localparam int LAT = 2;
  localparam int DEP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_pc;
  logic        flush;
  logic [63:0] mem_raddr, mem_rdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_inst;
  logic [63:0] rsp_pc;
  logic        rsp_err;
  logic        busy;

  imem_responder #(
    .ADDR_W  (64),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .flush     (flush),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_pc    (rsp_pc),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Backing-store contents: one known word, a hash elsewhere.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00100093_00000413;
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0] + 32'h1234_5678};
  endfunction

  always_comb mem_rdata = mem_word(mem_raddr);

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   cnt = 0;
  int   last_pop = -1;
  bit   fresh = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected response from the fetch rules for a pc accepted at cycle acc.
  function automatic exp_t predict(input logic [63:0] pc, input int acc);
    exp_t e;
    logic [63:0] w;
    w     = mem_word({pc[63:3], 3'b000});
    e.pc  = pc;
    e.acc = acc;
    e.err = (pc[1:0] != 2'b00);
    if (e.err)      e.inst = 32'h0;
    else if (pc[2]) e.inst = w[63:32];
    else            e.inst = w[31:0];
    return e;
  endfunction

  // Monitor: a response appears when its latency has elapsed and the one
  // before it has been taken; it stays at the head until taken.
  always @(negedge clk) begin
    bit exp_valid;
    bit exp_ready;
    int due;
    exp_t h;
    if (!rst_n) begin
      chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("reset_req_ready", 64'(req_ready), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_rsp_data", {31'h0, rsp_err, rsp_inst}, 64'h0);
      chk("reset_rsp_pc", rsp_pc, 64'h0);
      q.delete();
      cnt      = 0;
      last_pop = -1;
      fresh    = 1'b1;
    end else begin
      exp_valid = 1'b0;
      if (q.size() > 0) begin
        h   = q[0];
        due = h.acc + LAT;
        if (last_pop + 1 > due) due = last_pop + 1;
        exp_valid = (cyc >= due);
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (exp_valid && rsp_valid) begin
        chk("rsp_inst", 64'(rsp_inst), 64'(h.inst));
        chk("rsp_pc", rsp_pc, h.pc);
        chk("rsp_err", 64'(rsp_err), 64'(h.err));
        if (h.pc == 64'h0000_0000_8000_0004)
          chk("known_inst", 64'(rsp_inst), 64'h0000_0000_0010_0093);
      end
      exp_ready = !fresh && !flush && (cnt < DEP);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(cnt != 0));
      fresh = 1'b0;
      if (flush) begin
        q.delete();
        cnt = 0;
      end else begin
        if (exp_valid && rsp_ready) begin
          void'(q.pop_front());
          cnt--;
          last_pop = cyc;
        end
        if (req_valid && exp_ready) begin
          q.push_back(predict(req_pc, cyc));
          cnt++;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] pc, input logic rr, input logic fl);
    req_valid = v;
    req_pc    = pc;
    rsp_ready = rr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, rr, 1'b0);
  endtask

  // Hold a request until accepted, bounded.
  task automatic send(input logic [63:0] pc, input logic rr);
    req_valid = 1'b1;
    req_pc    = pc;
    rsp_ready = rr;
    flush     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 64'h0, 64'h1);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_pc    = 64'h0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);

    // single fetch
    send(64'h8000_0004, 1'b1);
    idle(4, 1'b1);

    // back-to-back
    send(64'h8000_0000, 1'b1);
    send(64'h8000_0004, 1'b1);
    send(64'h8000_0008, 1'b1);
    idle(4, 1'b1);

    // backpressure with a pending request held
    send(64'h8000_0010, 1'b0);
    send(64'h8000_0018, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 64'h8000_0020, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'h8000_0020, 1'b1, 1'b0);
    idle(4, 1'b1);

    // misaligned
    send(64'h8000_0002, 1'b1);
    idle(4, 1'b1);

    // flush with two outstanding
    send(64'h8000_0040, 1'b0);
    send(64'h8000_0044, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    send(64'h8000_0100, 1'b1);
    idle(5, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      hi = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      lo = 32'h8000_0000 | (($urandom & 32'hFF) << 2);
      if ($urandom_range(0, 7) == 0) lo = lo | 32'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), {hi, lo},
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end
    idle(6, 1'b1);

    // async reset between edges with two outstanding
    send(64'h8000_0200, 1'b0);
    send(64'h8000_0208, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'h0);
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_ready", 64'(req_ready), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6, 1'b1);
    send(64'h8000_0300, 1'b1);
    idle(5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
